// File: rtl/tick_monitor.sv
// Tick monitor: measures tick-to-tick intervals, flags short/long/missing
// ticks, counts errors and asserts lock after a run of exact intervals.
// Ports:
//   clk_i          clock; all state updates on rising edge
//   rst_ni         asynchronous active-low reset
//   tick_i         carry pulse from tick generator
//   clear_i        synchronous clear of err_count, back to IDLE
//   period_o       last measured interval in clocks
//   period_valid_o one-cycle pulse when period_o updates
//   short_err_o    one-cycle pulse: last interval < EXPECT
//   long_err_o     one-cycle pulse: last interval > EXPECT
//   timeout_o      one-cycle pulse: no tick within EXPECT+SLACK clocks
//   locked_o       high while in LOCKED
//   err_count_o    saturating count of short/long/timeout events
module tick_monitor #(
   parameter int unsigned EXPECT = 65536,
   parameter int unsigned SLACK  = 16,
   parameter int unsigned LOCK_N = 4,
   localparam int unsigned CW    = $clog2(EXPECT + SLACK + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          tick_i,
   input  logic          clear_i,
   output logic [CW-1:0] period_o,
   output logic          period_valid_o,
   output logic          short_err_o,
   output logic          long_err_o,
   output logic          timeout_o,
   output logic          locked_o,
   output logic [7:0]    err_count_o
);

   localparam int unsigned GW = $clog2(LOCK_N + 1);

   localparam logic [CW-1:0] EXP_C = CW'(EXPECT);
   localparam logic [CW-1:0] MAX_C = CW'(EXPECT + SLACK);
   localparam logic [GW-1:0] LCK_C = GW'(LOCK_N);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [GW-1:0]   run_q, run_d;
   logic [CW-1:0]   period_q, period_d;
   logic            pv_q, pv_d;
   logic            short_q, short_d;
   logic            long_q, long_d;
   logic            to_q, to_d;
   logic [7:0]      err_q, err_d;
   logic            bump;
   logic [GW-1:0]   run_inc;

   // Good-run count saturates at LOCK_N so it never wraps while locked.
   assign run_inc = (run_q == LCK_C) ? LCK_C : run_q + GW'(1);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      period_d = period_q;
      pv_d     = 1'b0;
      short_d  = 1'b0;
      long_d   = 1'b0;
      to_d     = 1'b0;
      err_d    = err_q;
      bump     = 1'b0;
      if (clear_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         run_d   = '0;
         err_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (tick_i) begin
                  state_d = MEASURE;
                  cnt_d   = CW'(1);
               end
            end
            MEASURE, LOCKED: begin
               if (!tick_i) begin
                  if (cnt_q == MAX_C) begin
                     to_d    = 1'b1;
                     bump    = 1'b1;
                     run_d   = '0;
                     cnt_d   = '0;
                     state_d = IDLE;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end else begin
                  period_d = cnt_q;
                  pv_d     = 1'b1;
                  cnt_d    = CW'(1);
                  if (cnt_q == EXP_C) begin
                     run_d = run_inc;
                     if (run_inc == LCK_C) begin
                        state_d = LOCKED;
                     end
                  end else begin
                     short_d = (cnt_q < EXP_C);
                     long_d  = (cnt_q > EXP_C);
                     bump    = 1'b1;
                     run_d   = '0;
                     state_d = MEASURE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
         if (bump && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         run_q    <= '0;
         period_q <= '0;
         pv_q     <= 1'b0;
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         to_q     <= 1'b0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
         period_q <= period_d;
         pv_q     <= pv_d;
         short_q  <= short_d;
         long_q   <= long_d;
         to_q     <= to_d;
         err_q    <= err_d;
      end
   end

   assign period_o       = period_q;
   assign period_valid_o = pv_q;
   assign short_err_o    = short_q;
   assign long_err_o     = long_q;
   assign timeout_o      = to_q;
   assign locked_o       = (state_q == LOCKED);
   assign err_count_o    = err_q;

endmodule

// File: doc/tick_monitor.md
Name: tick_monitor

Overview:
- Consumer end of the periodic carry-pulse interface produced by the 16-bit free-running tick generator (one-cycle pulse every 65536 clocks).
- Measures the interval between incoming tick pulses and reports each interval.
- Flags short intervals, long intervals and missing pulses.
- Asserts a lock indication after a run of correct intervals; used to qualify the tick source before downstream timers use it.

Parameters:
- EXPECT, 65536: required tick period in clocks (>= 2).
- SLACK, 16: extra clocks allowed past EXPECT before a missing pulse is declared (>= 1).
- LOCK_N, 4: consecutive exact intervals required to assert locked (>= 1).
- CW, $clog2(EXPECT+SLACK+1): derived width of interval counter and period output; not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately when low.
- tick  input  1  carry pulse from tick generator; sampled at posedge; high = one tick per cycle.
- clear  input  1  synchronous; clears err_count and returns to IDLE.
- period  output  CW  last measured interval in clocks.
- period_valid  output  1  one-cycle pulse when period updates.
- short_err  output  1  one-cycle pulse: last interval < EXPECT.
- long_err  output  1  one-cycle pulse: last interval > EXPECT.
- timeout  output  1  one-cycle pulse: no tick within EXPECT+SLACK clocks.
- locked  output  1  high while in LOCKED.
- err_count  output  8  saturating count of short/long/timeout events.

Behaviour:
- Reset (reset low, async):
  - state=IDLE; cnt=0; good_run=0.
  - All outputs 0.
  - Released synchronously into normal operation.
- All outputs are registered. Pulse outputs are high exactly one cycle, the cycle after the qualifying posedge.
- States: IDLE (no reference tick yet), MEASURE, LOCKED.
- IDLE:
  - tick=1 → MEASURE, cnt<=1.
  - No period_valid for this first tick.
- MEASURE/LOCKED, tick=0:
  - cnt<=cnt+1.
  - If cnt==EXPECT+SLACK: instead timeout pulse, err_count++, good_run<=0, locked<=0, state<=IDLE.
- MEASURE/LOCKED, tick=1:
  - period<=cnt (interval = tick-to-tick distance in cycles); period_valid pulse; cnt<=1.
  - cnt==EXPECT: good_run<=min(good_run+1, LOCK_N). When the new value reaches LOCK_N → LOCKED, locked<=1 (the same cycle as that period_valid).
  - cnt<EXPECT: short_err pulse; err_count++; good_run<=0; locked<=0; state<=MEASURE.
  - cnt>EXPECT (up to and including EXPECT+SLACK): long_err pulse; same recovery as short.
  - The interval measurement restarts from this tick in all three cases.
- clear=1 (synchronous):
  - err_count<=0; state<=IDLE; cnt<=0; good_run<=0; locked<=0.
  - No pulses that cycle. Clear has priority over tick: a tick in the same cycle is ignored.
- err_count saturates at 255; further errors still pulse the error outputs.
- Only one of period_valid-with-error / timeout can occur per cycle; error flags never coincide with timeout.
- Back-to-back ticks (interval 1) are legal input and report period=1 with short_err.
- reset low mid-interval aborts the measurement. The first tick after release is treated as the IDLE reference tick.

Test Plan (EXPECT=8, SLACK=2, LOCK_N=3):
- Assert reset low mid-interval while locked → locked, period, err_count read 0 in the same cycle, before any clock edge; first tick after release gives no period_valid.
- Ticks at cycles 10,18,26,34 → no period_valid at 10; period=8 with period_valid after 18, 26 and 34; locked rises with the 34 pulse; err_count=0.
- Locked, next tick 5 cycles later → period=5, short_err=1 for one cycle, locked=0, err_count=1. Three further 8-cycle intervals → locked again.
- Locked, tick 9 cycles later → period=9, long_err pulse, err_count+1. Next gap 10 cycles → long_err (boundary EXPECT+SLACK).
- Tick then no tick for 11 cycles → timeout pulse once (cnt hit 10, no tick), state IDLE. Next tick gives no period_valid; the following tick 8 later gives period=8.
- Clear asserted together with tick → err_count=0, no period_valid, tick ignored. Then force 300 short intervals → err_count saturates at 255.
